// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin arbiter sharing one 32-bit barrel shifter between NREQ requesters
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_ready [NREQ]    per-requester request handshake (ready is one-hot or zero)
//   req_a [32*NREQ]               operand, slice i = [32*i+31:32*i]
//   req_amount [5*NREQ]           shift amount per requester
//   req_right/req_arth [NREQ]     direction (1 = right) and arithmetic select (right only)
//   rsp_valid/rsp_ready           registered response handshake
//   rsp_id [IDW], rsp_result [32] owning requester and shifted value
//   conflict_cnt [16]             saturating contention count, present only with SHIFT_ARB_STATS_EN
module shift_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [32*NREQ-1:0]  req_a,
    input  logic [5*NREQ-1:0]   req_amount,
    input  logic [NREQ-1:0]     req_right,
    input  logic [NREQ-1:0]     req_arth,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
`ifdef SHIFT_ARB_STATS_EN
    output logic [31:0]         rsp_result,
    output logic [15:0]         conflict_cnt
`else
    output logic [31:0]         rsp_result
`endif
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state, state_nxt;
    logic [IDW-1:0] rr_ptr, gid;
    logic [NREQ-1:0] grant;
    logic found, can_accept, accept, right_sel, arth_sel;
    logic [31:0] a_sel, sra, shifted;
    logic [4:0] amt_sel;
    int idx;

    // Rotating priority scan starting at rr_ptr; the winner's payload is muxed out in the same pass.
    always_comb begin
        grant     = '0;
        gid       = '0;
        found     = 1'b0;
        idx       = 0;
        a_sel     = '0;
        amt_sel   = '0;
        right_sel = 1'b0;
        arth_sel  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gid        = IDW'(idx);
                a_sel      = req_a[32*idx +: 32];
                amt_sel    = req_amount[5*idx +: 5];
                right_sel  = req_right[idx];
                arth_sel   = req_arth[idx];
            end
        end
    end

    // Arithmetic shift kept in its own signal so the signed operand is not coerced unsigned by the mux.
    always_comb begin
        sra     = $signed(a_sel) >>> amt_sel;
        shifted = right_sel ? (arth_sel ? sra : a_sel >> amt_sel) : a_sel << amt_sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = accept ? FULL : (rsp_ready ? EMPTY : state);
    end

    always_comb begin
        rsp_valid  = state == FULL;
        can_accept = !rsp_valid || rsp_ready;
        req_ready  = (rst_n && can_accept) ? grant : '0;
        accept     = |req_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id     <= '0;
            rsp_result <= '0;
            rr_ptr     <= '0;
        end else if (accept) begin
            rsp_id     <= gid;
            rsp_result <= shifted;
            rr_ptr     <= (gid == IDW'(NREQ-1)) ? '0 : gid + 1'b1;
        end
    end

`ifdef SHIFT_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            conflict_cnt <= '0;
        else if ($countones(req_valid) > 1 && can_accept && conflict_cnt != 16'hFFFF)
            conflict_cnt <= conflict_cnt + 16'd1;
    end
`endif
endmodule
